instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//   Consumer of the program counter. Reads pcout, issues a read request to
//   instruction memory and waits for the acknowledge. Latches the returned
//   word into the instruction register (IR) and offers it to decode on a
//   valid/ready handshake. Pulses incpc to advance the PC after each
//   completed fetch.
// PARAMETERS
//   ADDR_W      8    word address width into imem; uses pcout[ADDR_W-1:0]
//   INSTR_W     32   instruction width
//   TIMEOUT_CYC 16   REQ cycles without ack before a fetch error (>=2)
// PORTS
//   clk        in   1        clock, all state updates on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   run        in   1        fetch enable
//   pcout      in   28       program counter value
//   incpc      out  1        one-cycle PC-increment pulse
//   mem_addr   out  ADDR_W   imem word address
//   mem_rd_req out  1        imem read request
//   mem_rd_ack in   1        imem acknowledge; mem_rdata is valid in the same cycle
//   mem_rdata  in   INSTR_W  imem read data
//   ir_out     out  INSTR_W  fetched instruction
//   ir_valid   out  1        ir_out holds an unconsumed instruction
//   ir_ready   in   1        decode accepts ir_out this cycle
//   clr_err    in   1        clears fetch_err and leaves ERR
//   fetch_err  out  1        sticky timeout flag
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; every output is 0; wait counter is 0.
//     - Any transaction in flight is abandoned immediately.
//   FSM states: IDLE, REQ, INC, ERR.
//   IDLE -> REQ:
//     - Taken when run=1 and (ir_valid=0 or ir_ready=1).
//     - On that edge, mem_addr <= pcout[ADDR_W-1:0] and mem_rd_req <= 1.
//     - The entry condition guarantees ir_valid=0 throughout REQ.
//   REQ:
//     - mem_rd_req and mem_addr stay stable until ack.
//     - The wait counter increments each cycle without ack.
//     - On ack: ir_out <= mem_rdata, ir_valid <= 1, mem_rd_req <= 0, state -> INC.
//     - If the counter reaches TIMEOUT_CYC-1 with no ack: mem_rd_req <= 0,
//       fetch_err <= 1, state -> ERR. No incpc is issued.
//     - Ack in the same cycle as the timeout: ack wins.
//     - run=0 during REQ does not withdraw the request; the fetch completes.
//   INC:
//     - incpc=1 for exactly this one cycle (Moore output); state -> IDLE.
//     - The PC updates on the INC->IDLE edge, so IDLE sees the new pcout.
//     - Minimum fetch period: REQ(1+wait) + INC(1) + IDLE(1) cycles.
//   ERR:
//     - Stays until clr_err=1; then fetch_err <= 0 and state -> IDLE.
//     - The faulting PC is not advanced, so the next fetch retries it.
//     - clr_err outside ERR is ignored.
//   IR handshake:
//     - ir_valid && ir_ready consumes the instruction and clears ir_valid.
//     - While ir_valid && !ir_ready, ir_out is held stable.
//   Wrap-around:
//     - Only pcout[ADDR_W-1:0] is used. pc=0xFF fetches address 0xFF;
//       after incpc the next fetch is address 0x00. No special case.
//   mem_rd_ack outside REQ is ignored.
// STRUCTURE
//   - Package cpu_pkg holds: fetch state enum (IDLE/REQ/INC/ERR),
//     PC_W=28, IMEM_ADDR_W=8, INSTR_W=32.
//   - One natural sub-module: fetch_timeout_ctr (clear/enable/expire).
//     Everything else sits in one always block for the FSM plus the IR register.
// TESTING
//   1. Reset: rst_n=0 mid-REQ -> mem_rd_req, incpc, ir_valid, fetch_err
//      all go 0 immediately.
//   2. pcout=0x05, ack after 3 cycles with rdata=0xDEADBEEF
//      -> mem_addr=0x05 stable while requesting; ir_out=0xDEADBEEF;
//      ir_valid=1; a single incpc pulse.
//   3. ir_ready=0 for 10 cycles, then 1 -> no new mem_rd_req until the cycle
//      after consume; ir_out unchanged throughout.
//   4. pcout=0xFF, then PC wraps -> fetch addresses 0xFF then 0x00 on
//      consecutive fetches.
//   5. No ack, TIMEOUT_CYC=16 -> req drops; fetch_err=1; no incpc.
//      clr_err -> refetch at the same address.
//   6. Ack coincident with timeout expiry -> normal completion; fetch_err stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and the fetch FSM state type for the CPU front end.
package cpu_pkg;

   localparam int PC_W        = 28;
   localparam int IMEM_ADDR_W = 8;
   localparam int INSTR_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_INC,
      ST_ERR
   } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts request cycles without ack; expire is combinational on the last allowed wait cycle.
// No backpressure: clr dominates en, and the count freezes once expire is reached.
module fetch_timeout_ctr #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int            CW   = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   assign expire = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one word at pcout into IR, pulses incpc, flags a sticky error on ack timeout.
// Latency 1+wait cycles to IR; a held (unconsumed) IR blocks the next request.
module instr_fetch_unit #(
   parameter int ADDR_W      = cpu_pkg::IMEM_ADDR_W,
   parameter int INSTR_W     = cpu_pkg::INSTR_W,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic [cpu_pkg::PC_W-1:0] pcout,
   output logic                    incpc,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_rd_req,
   input  logic                    mem_rd_ack,
   input  logic [INSTR_W-1:0]      mem_rdata,
   output logic [INSTR_W-1:0]      ir_out,
   output logic                    ir_valid,
   input  logic                    ir_ready,
   input  logic                    clr_err,
   output logic                    fetch_err
);

   import cpu_pkg::*;

   fetch_state_t state;
   logic         to_clr;
   logic         to_en;
   logic         to_expire;
   logic         unused_pc_hi;

   // Upper PC bits are outside imem; the word address simply wraps.
   assign unused_pc_hi = ^pcout[cpu_pkg::PC_W-1:ADDR_W];

   assign to_clr = (state != ST_REQ);
   assign to_en  = (state == ST_REQ) && !mem_rd_ack;

   fetch_timeout_ctr #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (to_clr),
      .en    (to_en),
      .expire(to_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mem_addr   <= '0;
         mem_rd_req <= 1'b0;
         incpc      <= 1'b0;
         ir_out     <= '0;
         ir_valid   <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               // Only start when the IR slot is free or being freed this cycle.
               if (run && (!ir_valid || ir_ready)) begin
                  mem_addr   <= pcout[ADDR_W-1:0];
                  mem_rd_req <= 1'b1;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_rd_ack) begin
                  ir_out     <= mem_rdata;
                  ir_valid   <= 1'b1;
                  mem_rd_req <= 1'b0;
                  incpc      <= 1'b1;
                  state      <= ST_INC;
               end else if (to_expire) begin
                  mem_rd_req <= 1'b0;
                  fetch_err  <= 1'b1;
                  state      <= ST_ERR;
               end
            end
            ST_INC: begin
               incpc <= 1'b0;
               state <= ST_IDLE;
            end
            ST_ERR: begin
               if (clr_err) begin
                  fetch_err <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
